pipe_mem_wb_fwd: RTL and testbench
==================================

PIPE_MEM_WB_FWD -- requirements
Module: pipe_mem_wb_fwd

Interface
REQ-001 SHALL have parameter N, default 32: data word width in bits.
REQ-002 SHALL have parameter A, default 4: register-file address width in bits.
REQ-003 SHALL have parameter CW, default 32: retire-counter width in bits.
REQ-004 SHALL have port CLK, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port RST, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port Stall_i, input, 1: hold the stage contents.
REQ-007 SHALL have port Flush_i, input, 1: replace the incoming instruction with a bubble.
REQ-008 SHALL have port Valid_i, input, 1: MEM-stage instruction is real (not a bubble).
REQ-009 SHALL have port ReadData_i, input, N: data-memory read value.
REQ-010 SHALL have port AluResult_i, input, N: ALU result carried from MEM.
REQ-011 SHALL have port RF_WE_i, input, 1: instruction writes the register file.
REQ-012 SHALL have port WBSelect_i, input, 1: 0 selects ReadData, 1 selects AluResult.
REQ-013 SHALL have port A3_i, input, A: destination register address.
REQ-014 SHALL have ports Src1_i and Src2_i, input, A each: EX-stage source register addresses.
REQ-015 SHALL have port Valid_o, output, 1: registered valid bit.
REQ-016 SHALL have port RF_WE_o, output, 1: registered RF_WE qualified by Valid_o.
REQ-017 SHALL have port A3_o, output, A: registered destination address.
REQ-018 SHALL have port WBData_o, output, N: write-back data, muxed from registered fields.
REQ-019 SHALL have ports Fwd1_o and Fwd2_o, output, 1 each: forwarding hit for Src1_i and Src2_i.
REQ-020 SHALL have port RetireCount_o, output, CW: count of retired valid instructions.

Function
REQ-021 SHALL give a latency of one cycle: inputs sampled at edge k appear on outputs after edge k.
REQ-022 SHALL have Flush_i=1 load Valid=0, RF_WE=0 and keep data, WBSelect and A3 unchanged; flush SHALL override stall.
REQ-023 SHALL have Stall_i=1 with Flush_i=0 hold every register, including the counter.
REQ-024 SHALL load all fields from the inputs when Stall_i=0 and Flush_i=0.
REQ-025 SHALL drive RF_WE_o = RF_WE reg AND Valid reg, combinationally.
REQ-026 SHALL drive WBData_o = AluResult reg when the WBSelect reg is 1, else ReadData reg.
REQ-027 SHALL drive Fwd1_o = RF_WE_o AND (A3_o == Src1_i); Fwd2_o SHALL be the same with Src2_i; both combinational.
REQ-028 SHALL increment RetireCount_o by 1 at each edge where Valid_o=1 and Stall_i=0, ignoring Flush_i.
REQ-029 SHALL wrap RetireCount_o modulo 2^CW, so all-ones+1 gives 0 with no saturation or flag.
REQ-030 SHALL, when an edge both retires and loads a new instruction, count the old instruction and load the new one in the same cycle.

Reset
REQ-031 SHALL, when RST=0 at a rising edge, clear Valid, RF_WE, WBSelect, A3, ReadData, AluResult and RetireCount to 0.
REQ-032 SHALL give reset priority over Flush_i and Stall_i, including mid-stall.
REQ-033 SHALL hold Fwd1_o, Fwd2_o and RF_WE_o at 0 after reset until a valid writing instruction loads.

Structure
REQ-034 SHALL place constants WB_READDATA=1'b0 and WB_ALURESULT=1'b1 in shared package pipe_pkg.
REQ-035 SHALL implement each field register with sub-module pipe_reg_en, parametrised by width and reset value, with en/clr inputs.
REQ-036 SHALL keep the WB mux, forwarding compare and counter increment inside pipe_mem_wb_fwd.

Verification
REQ-037 SHALL test load and mux: ReadData_i=32'h7894ACD0, AluResult_i=32'h2, WBSelect_i=0, Valid_i=1, RF_WE_i=1, A3_i=3 -> after 1 edge WBData_o=32'h7894ACD0, RF_WE_o=1; with WBSelect_i=1 -> WBData_o=32'h2.
REQ-038 SHALL test stall: load A3=3, then Stall_i=1 for 3 edges with A3_i=5 -> A3_o stays 3 and RetireCount_o stays constant.
REQ-039 SHALL test flush over stall: Stall_i=1, Flush_i=1 -> after edge Valid_o=0, RF_WE_o=0, Fwd1_o=0 with Src1_i=A3_o.
REQ-040 SHALL test forwarding: A3_o=7, RF_WE_o=1, Src1_i=7, Src2_i=2 -> Fwd1_o=1, Fwd2_o=0; with Valid_i=0 loaded -> both 0.
REQ-041 SHALL test wrap: CW=4, 17 consecutive valid unstalled instructions -> RetireCount_o=0 after the 16th retire and 1 after the 17th.
REQ-042 SHALL test reset mid-stall: RST=0 during Stall_i=1 -> after edge all outputs 0, RetireCount_o=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-register slice.
//
// Contents:
//   WB_READDATA  - write-back select value that picks the data-memory read value
//   WB_ALURESULT - write-back select value that picks the ALU result
package pipe_pkg;

  localparam logic WB_READDATA  = 1'b0;
  localparam logic WB_ALURESULT = 1'b1;

endpackage

// File: rtl/pipe_reg_en.sv
// Generic pipeline field register with load enable and clear-to-zero.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset, loads RST_VAL
//   en    - load d into the register
//   clr   - load zero; wins over en so a bubble can be injected while stalled
//   d     - next value
//   q     - registered value
module pipe_reg_en #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset dominates clear, clear dominates load, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_mem_wb_fwd.sv
// MEM/WB pipeline register with write-back mux, forwarding compare and a
// retired-instruction counter.
//
// Ports:
//   CLK, RST              - clock and synchronous active-low reset
//   Stall_i, Flush_i      - hold the stage / turn the incoming slot into a bubble
//   Valid_i, RF_WE_i      - MEM-stage valid and register-write enable
//   ReadData_i, AluResult_i, WBSelect_i, A3_i - MEM-stage data fields
//   Src1_i, Src2_i        - EX-stage source addresses for forwarding compare
//   Valid_o, RF_WE_o, A3_o, WBData_o - registered WB-stage view
//   Fwd1_o, Fwd2_o        - WB-stage result matches Src1_i / Src2_i
//   RetireCount_o         - wrapping count of retired valid instructions
module pipe_mem_wb_fwd
  import pipe_pkg::*;
#(
  parameter int N  = 32,
  parameter int A  = 4,
  parameter int CW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Stall_i,
  input  logic          Flush_i,
  input  logic          Valid_i,
  input  logic [N-1:0]  ReadData_i,
  input  logic [N-1:0]  AluResult_i,
  input  logic          RF_WE_i,
  input  logic          WBSelect_i,
  input  logic [A-1:0]  A3_i,
  input  logic [A-1:0]  Src1_i,
  input  logic [A-1:0]  Src2_i,
  output logic          Valid_o,
  output logic          RF_WE_o,
  output logic [A-1:0]  A3_o,
  output logic [N-1:0]  WBData_o,
  output logic          Fwd1_o,
  output logic          Fwd2_o,
  output logic [CW-1:0] RetireCount_o
);

  logic          load;
  logic          retire;
  logic          valid_q;
  logic          rf_we_q;
  logic          wb_sel_q;
  logic [A-1:0]  a3_q;
  logic [N-1:0]  read_data_q;
  logic [N-1:0]  alu_result_q;
  logic [CW-1:0] count_q;

  // A flush only kills the control bits; data fields simply hold, since a
  // bubble's payload is never consumed.
  assign load   = !Stall_i && !Flush_i;
  // The instruction currently in WB leaves the stage on any unstalled edge,
  // whether or not the incoming slot is flushed.
  assign retire = valid_q && !Stall_i;

  pipe_reg_en #(.W(1)) u_valid (
    .clk(CLK), .rst_n(RST), .en(load), .clr(Flush_i), .d(Valid_i), .q(valid_q)
  );

  pipe_reg_en #(.W(1)) u_rf_we (
    .clk(CLK), .rst_n(RST), .en(load), .clr(Flush_i), .d(RF_WE_i), .q(rf_we_q)
  );

  pipe_reg_en #(.W(1)) u_wb_sel (
    .clk(CLK), .rst_n(RST), .en(load), .clr(1'b0), .d(WBSelect_i), .q(wb_sel_q)
  );

  pipe_reg_en #(.W(A)) u_a3 (
    .clk(CLK), .rst_n(RST), .en(load), .clr(1'b0), .d(A3_i), .q(a3_q)
  );

  pipe_reg_en #(.W(N)) u_read_data (
    .clk(CLK), .rst_n(RST), .en(load), .clr(1'b0), .d(ReadData_i), .q(read_data_q)
  );

  pipe_reg_en #(.W(N)) u_alu_result (
    .clk(CLK), .rst_n(RST), .en(load), .clr(1'b0), .d(AluResult_i), .q(alu_result_q)
  );

  // Counter wraps naturally through the fixed-width add.
  pipe_reg_en #(.W(CW)) u_retire_count (
    .clk(CLK), .rst_n(RST), .en(retire), .clr(1'b0),
    .d(count_q + CW'(1)), .q(count_q)
  );

  assign Valid_o       = valid_q;
  assign RF_WE_o       = rf_we_q && valid_q;
  assign A3_o          = a3_q;
  assign WBData_o      = (wb_sel_q == WB_ALURESULT) ? alu_result_q : read_data_q;
  assign Fwd1_o        = RF_WE_o && (a3_q == Src1_i);
  assign Fwd2_o        = RF_WE_o && (a3_q == Src2_i);
  assign RetireCount_o = count_q;

endmodule

// File: tb/tb_pipe_mem_wb_fwd.sv
// Scoreboard bench for pipe_mem_wb_fwd (CW=4 so counter wrap is reachable).
// Driver applies inputs on the falling edge and pushes the expected post-edge
// outputs; the monitor pops one entry 2 time units after each rising edge.
module tb_pipe_mem_wb_fwd;

  localparam int N  = 32;
  localparam int A  = 4;
  localparam int CW = 4;

  typedef struct {
    bit          rst_n;
    bit          stall;
    bit          flush;
    bit          valid;
    bit          we;
    bit          sel;
    bit [A-1:0]  a3;
    bit [A-1:0]  src1;
    bit [A-1:0]  src2;
    bit [N-1:0]  rd;
    bit [N-1:0]  alu;
  } stim_t;

  typedef struct {
    bit          valid;
    bit          we;
    bit [A-1:0]  a3;
    bit [N-1:0]  wb;
    bit          fwd1;
    bit          fwd2;
    bit [CW-1:0] cnt;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          Stall_i = 1'b0;
  logic          Flush_i = 1'b0;
  logic          Valid_i = 1'b0;
  logic [N-1:0]  ReadData_i = '0;
  logic [N-1:0]  AluResult_i = '0;
  logic          RF_WE_i = 1'b0;
  logic          WBSelect_i = 1'b0;
  logic [A-1:0]  A3_i = '0;
  logic [A-1:0]  Src1_i = '0;
  logic [A-1:0]  Src2_i = '0;
  logic          Valid_o;
  logic          RF_WE_o;
  logic [A-1:0]  A3_o;
  logic [N-1:0]  WBData_o;
  logic          Fwd1_o;
  logic          Fwd2_o;
  logic [CW-1:0] RetireCount_o;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference view of the instruction sitting in WB plus the retire count.
  bit          m_valid, m_we, m_sel;
  bit [A-1:0]  m_a3;
  bit [N-1:0]  m_rd, m_alu;
  int          m_retired;

  pipe_mem_wb_fwd #(.N(N), .A(A), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .Stall_i(Stall_i), .Flush_i(Flush_i),
    .Valid_i(Valid_i), .ReadData_i(ReadData_i), .AluResult_i(AluResult_i),
    .RF_WE_i(RF_WE_i), .WBSelect_i(WBSelect_i), .A3_i(A3_i),
    .Src1_i(Src1_i), .Src2_i(Src2_i), .Valid_o(Valid_o), .RF_WE_o(RF_WE_o),
    .A3_o(A3_o), .WBData_o(WBData_o), .Fwd1_o(Fwd1_o), .Fwd2_o(Fwd2_o),
    .RetireCount_o(RetireCount_o)
  );

  always #5 CLK = ~CLK;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  // Drive one cycle of inputs and record what the WB stage must show after
  // the coming rising edge.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(negedge CLK);
    RST         = s.rst_n;
    Stall_i     = s.stall;
    Flush_i     = s.flush;
    Valid_i     = s.valid;
    RF_WE_i     = s.we;
    WBSelect_i  = s.sel;
    A3_i        = s.a3;
    Src1_i      = s.src1;
    Src2_i      = s.src2;
    ReadData_i  = s.rd;
    AluResult_i = s.alu;

    if (!s.rst_n) begin
      m_valid = 0; m_we = 0; m_sel = 0; m_a3 = '0; m_rd = '0; m_alu = '0;
      m_retired = 0;
    end else begin
      if (m_valid && !s.stall) m_retired = m_retired + 1;
      if (s.flush) begin
        m_valid = 0;
        m_we    = 0;
      end else if (!s.stall) begin
        m_valid = s.valid; m_we = s.we; m_sel = s.sel; m_a3 = s.a3;
        m_rd = s.rd; m_alu = s.alu;
      end
    end

    e.valid = m_valid;
    e.we    = m_valid && m_we;
    e.a3    = m_a3;
    e.wb    = m_sel ? m_alu : m_rd;
    e.fwd1  = e.we && (m_a3 == s.src1);
    e.fwd2  = e.we && (m_a3 == s.src2);
    e.cnt   = CW'(m_retired % (1 << CW));
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] act,
                             input logic [N-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare every post-edge snapshot against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("valid",  N'(Valid_o),       N'(e.valid));
        checkOutput("rf_we",  N'(RF_WE_o),       N'(e.we));
        checkOutput("a3",     N'(A3_o),          N'(e.a3));
        checkOutput("wbdata", WBData_o,          e.wb);
        checkOutput("fwd1",   N'(Fwd1_o),        N'(e.fwd1));
        checkOutput("fwd2",   N'(Fwd2_o),        N'(e.fwd2));
        checkOutput("count",  N'(RetireCount_o), N'(e.cnt));
      end
    end
  end

  initial begin
    stim_t s;
    int drain;

    s = idle(); s.rst_n = 0;
    applyStimulus(s);
    applyStimulus(s);

    // Load and write-back mux
    s = idle(); s.valid = 1; s.we = 1; s.a3 = 3;
    s.rd = 32'h7894ACD0; s.alu = 32'h2; s.sel = 0;
    applyStimulus(s);
    s.sel = 1;
    applyStimulus(s);

    // Stall holds A3 and the count
    s = idle(); s.valid = 1; s.we = 1; s.a3 = 3; s.rd = 32'h11; s.alu = 32'h22;
    applyStimulus(s);
    s.stall = 1; s.a3 = 5;
    repeat (3) applyStimulus(s);

    // Flush overrides stall; forward must drop even though address matches
    s.flush = 1; s.src1 = 3;
    applyStimulus(s);

    // Forwarding hit, then a bubble clears it
    s = idle(); s.valid = 1; s.we = 1; s.a3 = 7; s.src1 = 7; s.src2 = 2;
    s.alu = 32'hCAFE; s.sel = 1;
    applyStimulus(s);
    s.valid = 0;
    applyStimulus(s);

    // Counter wrap: 17 retires need 18 edges of valid traffic
    s = idle(); s.rst_n = 0;
    applyStimulus(s);
    for (int i = 0; i < 18; i++) begin
      s = idle(); s.valid = 1; s.we = 1; s.a3 = A'(i); s.rd = 32'(i * 3);
      applyStimulus(s);
    end

    // Reset during a stall
    s = idle(); s.stall = 1; s.valid = 1; s.we = 1;
    applyStimulus(s);
    s.rst_n = 0;
    applyStimulus(s);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 39) != 0);
      s.stall = ($urandom_range(0, 3) == 0);
      s.flush = ($urandom_range(0, 5) == 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.we    = ($urandom_range(0, 2) != 0);
      s.sel   = 1'($urandom);
      s.a3    = A'($urandom_range(0, 3));
      s.src1  = A'($urandom_range(0, 3));
      s.src2  = A'($urandom_range(0, 3));
      s.rd    = $urandom;
      s.alu   = $urandom;
      applyStimulus(s);
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      @(negedge CLK);
      drain++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
